// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 operation codes (MUL..REMU)
//   - 2-bit FSM state encoding
//   - helpers telling which operands an op treats as signed
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Operand A (rs1) is signed for MUL, MULH, MULHSU, DIV and REM.
  // MUL is treated as signed/signed; its low half is identical either way.
  function automatic logic is_signed_a(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // Operand B (rs2) is signed for MUL, MULH, DIV and REM.
  function automatic logic is_signed_b(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per cycle.
// Multiply is shift-add over a {hi,lo} accumulator; divide is restoring
// shift-subtract over {R,Q} held in the same accumulator. Operands are
// converted to magnitudes on start, and signs are re-applied in FIX.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request pulse, sampled only in IDLE
//   funct3              operation select (MUL..REMU)
//   rs1_data, rs2_data  operand A (multiplicand/dividend), B (multiplier/divisor)
//   rd_in               destination register index
//   busy                high in RUN and FIX
//   done                one-cycle pulse when result is valid
//   result, rd_out      registered result and latched destination
//   we_out              done qualified with rd_out != 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = 2 * XLEN + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            neg_main_q, neg_main_d;  // product / quotient sign
  logic            neg_rem_q, neg_rem_d;    // remainder sign (= sign of A)
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            done_q, done_d;
  logic            we_q, we_d;

  // Start-time operand conditioning
  logic            sa_s, sb_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s;

  assign sa_s    = is_signed_a(funct3) & rs1_data[XLEN-1];
  assign sb_s    = is_signed_b(funct3) & rs2_data[XLEN-1];
  assign abs_a_s = sa_s ? (~rs1_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data;
  assign abs_b_s = sb_s ? (~rs2_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data;

  // Multiply step: hi is XLEN+1 bits so the carry of hi+A shifts back in.
  logic [XLEN:0]   mul_sum_s;
  logic [AW-1:0]   mul_next_s;

  assign mul_sum_s  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[XLEN-1:0]} >> 1;

  // Divide step: R < B always holds after a step, so R's top bit is 0 and
  // only the low XLEN bits of R take part in the left shift.
  logic [XLEN:0]   r_sh_s, r_sub_s;
  logic [XLEN-1:0] q_sh_s;
  logic            r_ge_s;
  logic [AW-1:0]   div_next_s;

  assign r_sh_s     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign q_sh_s     = {acc_q[XLEN-2:0], 1'b0};
  assign r_ge_s     = r_sh_s >= {1'b0, opb_q};
  assign r_sub_s    = r_sh_s - {1'b0, opb_q};
  assign div_next_s = r_ge_s ? {r_sub_s, q_sh_s[XLEN-1:1], 1'b1} : {r_sh_s, q_sh_s};

  // Sign fix-up and special cases
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, a_orig_s, fix_val_s;
  logic              div_zero_s, div_ovf_s, sb_rec_s;

  assign prod_s     = acc_q[2*XLEN-1:0];
  assign prod_fix_s = neg_main_q ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
  assign quo_fix_s  = neg_main_q ? (~acc_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                                 : acc_q[XLEN-1:0];
  assign rem_fix_s  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                                : acc_q[2*XLEN-1:XLEN];
  // rs1 is rebuilt from its magnitude and sign rather than stored again.
  assign a_orig_s   = neg_rem_q ? (~opa_q + {{(XLEN-1){1'b0}}, 1'b1}) : opa_q;
  assign sb_rec_s   = neg_main_q ^ neg_rem_q;
  assign div_zero_s = (opb_q == {XLEN{1'b0}});
  assign div_ovf_s  = ((op_q == OP_DIV) || (op_q == OP_REM)) && neg_rem_q && sb_rec_s &&
                      (opa_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (opb_q == {{(XLEN-1){1'b0}}, 1'b1});

  // Result selection for the FIX state
  always_comb begin
    fix_val_s = {XLEN{1'b0}};
    case (op_q)
      OP_MUL:                        fix_val_s = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_s) begin
          fix_val_s = {XLEN{1'b1}};
        end else if (div_ovf_s) begin
          fix_val_s = {1'b1, {(XLEN-1){1'b0}}};
        end else begin
          fix_val_s = quo_fix_s;
        end
      end
      OP_REM, OP_REMU: begin
        if (div_zero_s) begin
          fix_val_s = a_orig_s;
        end else if (div_ovf_s) begin
          fix_val_s = {XLEN{1'b0}};
        end else begin
          fix_val_s = rem_fix_s;
        end
      end
      default:                       fix_val_s = {XLEN{1'b0}};
    endcase
  end

  // FSM next-state and datapath next-value logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    rd_d       = rd_q;
    done_d     = 1'b0;
    we_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d       = funct3;
          rd_d       = rd_in;
          opa_d      = abs_a_s;
          opb_d      = abs_b_s;
          neg_main_d = sa_s ^ sb_s;
          neg_rem_d  = sa_s;
          cnt_d      = {CW{1'b0}};
          // Multiply: hi=0, lo=|B|. Divide: R=0, Q=|A|.
          if (funct3[2]) begin
            acc_d = {{(XLEN+1){1'b0}}, abs_a_s};
          end else begin
            acc_d = {{(XLEN+1){1'b0}}, abs_b_s};
          end
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (op_q[2]) begin
          acc_d = div_next_s;
        end else begin
          acc_d = mul_next_s;
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        result_d = fix_val_s;
        done_d   = 1'b1;
        we_d     = (rd_q != 5'd0);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= 3'b000;
      opa_q      <= {XLEN{1'b0}};
      opb_q      <= {XLEN{1'b0}};
      acc_q      <= {AW{1'b0}};
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= {XLEN{1'b0}};
      rd_q       <= 5'd0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      we_q       <= we_d;
    end
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done   = done_q;
  assign we_out = we_q;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out),
    .we_out   (we_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch one op and follow it to completion.
  // repulse=1 pulses start again (other operands) 10 cycles in.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit repulse);
    int cycles;
    int busy_cnt;
    int extra_done;
    @(negedge clk);
    start = 1'b1; funct3 = op; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd31;
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_cnt++;
      if (repulse && cycles == 10) begin
        start = 1'b1; funct3 = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cycles), 32'd33);
    check({tag, " result"}, result, exp);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, " we_out"}, {31'd0, we_out}, {31'd0, (rd != 5'd0)});
    if (repulse) begin
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
    end
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check({tag, " extra_done"}, 32'(extra_done), 32'd0);
    check({tag, " hold"}, result, exp);
  endtask

  initial begin
    int busy_cnt;
    int cycles;
    int extra_done;
    rst = 1'b1; start = 1'b0; funct3 = 3'b000;
    rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, busy},   32'd0);
    check("reset done",   {31'd0, done},   32'd0);
    check("reset we_out", {31'd0, we_out}, 32'd0);
    check("reset result", result,          32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    // Test 1, with explicit busy-length check
    @(negedge clk);
    start = 1'b1; funct3 = OP_MUL; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_in = 5'd5;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_cnt++;
    end
    check("mul latency", 32'(cycles), 32'd33);
    check("mul busy_cycles", 32'(busy_cnt), 32'd33);
    check("mul result", result, 32'hFFFF_FFEB);
    check("mul rd_out", {27'd0, rd_out}, 32'd5);
    check("mul we_out", {31'd0, we_out}, 32'd1);
    @(posedge clk); #1;
    check("mul done_pulse", {31'd0, done}, 32'd0);

    // Test 2
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1'b0);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0);
    // Test 3
    run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b0);
    run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",   OP_DIVU,   32'd100, 32'd7, 5'd7, 32'd14, 1'b0);
    run_op("remu",   OP_REMU,   32'd100, 32'd7, 5'd8, 32'd2, 1'b0);
    // Test 4
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b0);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0",  OP_REM,  32'd5, 32'd0, 5'd13, 32'd5, 1'b0);
    run_op("div_by0n", OP_DIV,  32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0n", OP_REM,  32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9, 1'b0);
    // Test 5
    run_op("repulse", OP_MUL, 32'd6, 32'd9, 5'd5, 32'd54, 1'b1);
    run_op("rd0",     OP_REMU, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0);

    // Test 6: reset 15 cycles into RUN aborts the operation
    @(negedge clk);
    start = 1'b1; funct3 = OP_MULHU; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h0000_0010; rd_in = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("abort busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy",   {31'd0, busy},   32'd0);
    check("abort result", result,          32'd0);
    check("abort done",   {31'd0, done},   32'd0);
    check("abort rd_out", {27'd0, rd_out}, 32'd0);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("abort no_done", 32'(extra_done), 32'd0);
    run_op("after_abort", OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd20, 32'h0000_000F, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
